// File: rtl/even_parity_pkg.sv
// Shared definitions for the even-parity serial link (transmitter and checker).
// Contents: frame state encoding, line levels for start/stop/idle, and the
// parity helper used on both ends so they can never disagree.
package even_parity_pkg;

  // Widest data word the parity helper handles; narrower words are
  // zero-extended, which does not change an XOR reduction.
  localparam int MAX_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

  // Even parity bit: makes the count of ones across data+parity even.
  function automatic logic even_parity(input logic [MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/even_parity_serial_tx_if.sv
// Parallel word handshake into the even-parity transmitter.
// Signals: in_valid (master->slave), in_ready (slave->master),
//          in_data[DATA_W] (master->slave, sampled on accept).
interface even_parity_serial_tx_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/even_parity_serial_tx_bit_tick.sv
// Bit-time divider: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit period. Shared with the future serial receiver.
// Ports: clk_i, rst_i (sync, active high), clear_i (hold count at 0),
//        bit_end_o (high on the final cycle of the current bit).
module bit_tick_counter #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  output logic bit_end_o
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;

  assign bit_end_o = (cnt_q == LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i || bit_end_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/even_parity_serial_tx.sv
// Even-parity serial transmitter. Accepts a word over a valid/ready
// handshake and sends start, data LSB-first, even parity, stop; each bit
// is held CLKS_PER_BIT clocks.
// Ports: clk_i, rst_i (sync, active high), bus (handshake slave),
//        tx_serial_o (line, idle high), tx_busy_o (frame in progress),
//        frame_done_o (pulse on last stop-bit cycle),
//        parity_out_o (parity of the most recently accepted word).
//
// state  | meaning
// IDLE   | line high, in_ready high, waiting for a word
// START  | line low for one bit time
// DATA   | shifting data out LSB-first, DATA_W bit times
// PARITY | line carries the latched parity bit
// STOP   | line high for one bit time, frame_done on its last cycle
module even_parity_serial_tx
  import even_parity_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  even_parity_serial_tx_if.slave  bus,
  output logic                    tx_serial_o,
  output logic                    tx_busy_o,
  output logic                    frame_done_o,
  output logic                    parity_out_o
);
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

  state_e            state_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_nxt;
  logic [IW-1:0]     bit_idx_q;
  logic              parity_q;
  logic              tx_serial_q;
  logic              tx_busy_q;
  logic              bit_end;
  logic              accept;

  assign bus.in_ready = (state_q == IDLE) && !rst_i;
  assign accept       = bus.in_valid && bus.in_ready;
  assign shift_nxt    = shift_q >> 1;

  // Counter is held at zero in IDLE so the start bit always gets a full
  // bit time beginning on the cycle after accept.
  bit_tick_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (state_q == IDLE),
    .bit_end_o (bit_end)
  );

  // The line level is registered alongside each transition so it changes
  // on the same edge as the state it belongs to.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      parity_q    <= 1'b0;
      tx_serial_q <= IDLE_LVL;
      tx_busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            shift_q     <= bus.in_data;
            parity_q    <= even_parity(MAX_W'(bus.in_data));
            state_q     <= START;
            tx_serial_q <= START_LVL;
            tx_busy_q   <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state_q     <= DATA;
            bit_idx_q   <= '0;
            tx_serial_q <= shift_q[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            shift_q <= shift_nxt;
            if (bit_idx_q == LAST_IDX) begin
              state_q     <= PARITY;
              tx_serial_q <= parity_q;
            end else begin
              bit_idx_q   <= bit_idx_q + 1'b1;
              tx_serial_q <= shift_nxt[0];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state_q     <= STOP;
            tx_serial_q <= STOP_LVL;
          end
        end
        STOP: begin
          if (bit_end) begin
            state_q     <= IDLE;
            tx_serial_q <= IDLE_LVL;
            tx_busy_q   <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          tx_serial_q <= IDLE_LVL;
          tx_busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign tx_serial_o  = tx_serial_q;
  assign tx_busy_o    = tx_busy_q;
  assign parity_out_o = parity_q;
  assign frame_done_o = (state_q == STOP) && bit_end;

endmodule

// File: tb/tb_even_parity_serial_tx.sv
// Directed bench for even_parity_serial_tx: three instances cover the
// default 8/4 build, the one-clock-per-bit build and a 3-bit loopback.
module tb_even_parity_serial_tx;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;

  // instance A: DATA_W=8, CLKS_PER_BIT=4
  even_parity_serial_tx_if #(.DATA_W(8)) a_if ();
  logic a_line, a_busy, a_done, a_par;
  // instance B: DATA_W=8, CLKS_PER_BIT=1
  even_parity_serial_tx_if #(.DATA_W(8)) b_if ();
  logic b_line, b_busy, b_done, b_par;
  // instance C: DATA_W=3, CLKS_PER_BIT=4
  even_parity_serial_tx_if #(.DATA_W(3)) c_if ();
  logic c_line, c_busy, c_done, c_par;

  even_parity_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) u_a (
    .clk_i(clk), .rst_i(rst), .bus(a_if), .tx_serial_o(a_line),
    .tx_busy_o(a_busy), .frame_done_o(a_done), .parity_out_o(a_par));
  even_parity_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) u_b (
    .clk_i(clk), .rst_i(rst), .bus(b_if), .tx_serial_o(b_line),
    .tx_busy_o(b_busy), .frame_done_o(b_done), .parity_out_o(b_par));
  even_parity_serial_tx #(.DATA_W(3), .CLKS_PER_BIT(4)) u_c (
    .clk_i(clk), .rst_i(rst), .bus(c_if), .tx_serial_o(c_line),
    .tx_busy_o(c_busy), .frame_done_o(c_done), .parity_out_o(c_par));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame on A; frame is the 11 line bits in send order (MSB first).
  // inject raises in_valid with 0xFF mid-DATA and leaves it asserted.
  task automatic run_frame_a(input logic [7:0] data, input logic [10:0] frame,
                             input logic par, input logic inject);
    logic [43:0] cap, exp_line, busy_v, done_v;
    int n;
    a_if.in_valid = 1'b1;
    a_if.in_data  = data;
    n = 0;
    while (!a_if.in_ready && n < 200) begin
      tick();
      n++;
    end
    chk("a_ready_wait", 64'(n < 200), 1);
    tick();
    a_if.in_valid = 1'b0;
    a_if.in_data  = 8'h00;
    chk("a_parity", a_par, par);
    for (int c = 0; c < 44; c++) begin
      if (inject && c == 9) begin
        a_if.in_valid = 1'b1;
        a_if.in_data  = 8'hFF;
      end
      if (inject && c == 20) chk("a_ready_in_frame", a_if.in_ready, 0);
      cap[43-c]      = a_line;
      busy_v[43-c]   = a_busy;
      done_v[43-c]   = a_done;
      exp_line[43-c] = frame[10 - c/4];
      if (c < 43) tick();
    end
    chk("a_line", cap, exp_line);
    chk("a_busy", busy_v, 44'hFFF_FFFF_FFFF);
    chk("a_done", done_v, 44'h1);
    tick();
    chk("a_ready_after", a_if.in_ready, 1);
    chk("a_idle_busy", a_busy, 0);
    chk("a_idle_line", a_line, 1);
    chk("a_par_hold", a_par, par);
  endtask

  logic [23:0] b_line_v, b_done_v, b_busy_v;
  logic        done_seen;
  logic [5:0]  rx;
  logic [2:0]  c_words [4] = '{3'b111, 3'b101, 3'b001, 3'b000};
  logic        c_pars  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  int          n;

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst = 1'b1;
    a_if.in_valid = 1'b0; a_if.in_data = '0;
    b_if.in_valid = 1'b0; b_if.in_data = '0;
    c_if.in_valid = 1'b0; c_if.in_data = '0;
    repeat (3) tick();

    // reset state
    chk("rst_line", a_line, 1);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_par", a_par, 0);
    chk("rst_ready", a_if.in_ready, 0);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", a_if.in_ready, 1);

    // 0xA5, parity 0
    run_frame_a(8'hA5, 11'b0_10100101_0_1, 1'b0, 1'b0);
    // 0x07, parity 1; receiver XOR over data+parity must be 0
    run_frame_a(8'h07, 11'b0_11100000_1_1, 1'b1, 1'b0);
    chk("a_even_07", ^{8'h07, a_par}, 0);
    // 0x3C with 0xFF offered mid-frame, then 0xFF accepted afterwards
    run_frame_a(8'h3C, 11'b0_00111100_0_1, 1'b0, 1'b1);
    run_frame_a(8'hFF, 11'b0_11111111_0_1, 1'b0, 1'b0);

    // reset mid-DATA aborts the frame
    a_if.in_valid = 1'b1;
    a_if.in_data  = 8'h5A;
    n = 0;
    while (!a_if.in_ready && n < 200) begin
      tick();
      n++;
    end
    tick();
    a_if.in_valid = 1'b0;
    repeat (15) tick();
    chk("mid_busy", a_busy, 1);
    rst = 1'b1;
    tick();
    chk("abort_line", a_line, 1);
    chk("abort_busy", a_busy, 0);
    chk("abort_done", a_done, 0);
    rst = 1'b0;
    #1;
    chk("abort_ready", a_if.in_ready, 1);
    done_seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      done_seen = done_seen | a_done | ~a_line;
      tick();
    end
    chk("abort_quiet", done_seen, 0);
    run_frame_a(8'h81, 11'b0_10000001_0_1, 1'b0, 1'b0);

    // CLKS_PER_BIT=1, valid held high: 0x01 then 0x03
    b_if.in_valid = 1'b1;
    b_if.in_data  = 8'h01;
    n = 0;
    while (!b_if.in_ready && n < 200) begin
      tick();
      n++;
    end
    chk("b_ready_wait", 64'(n < 200), 1);
    tick();
    b_if.in_data = 8'h03;
    for (int c = 0; c < 24; c++) begin
      if (c == 0)  chk("b_par_first", b_par, 1);
      if (c == 11) chk("b_par_hold", b_par, 1);
      if (c == 12) begin
        chk("b_par_second", b_par, 0);
        b_if.in_valid = 1'b0;
      end
      b_line_v[23-c] = b_line;
      b_done_v[23-c] = b_done;
      b_busy_v[23-c] = b_busy;
      if (c < 23) tick();
    end
    chk("b_line", b_line_v, 24'h407603);
    chk("b_done", b_done_v, 24'h002002);
    chk("b_busy", b_busy_v, 24'hFFEFFE);
    tick();

    // DATA_W=3 loopback into a 4-input even-parity check
    for (int w = 0; w < 4; w++) begin
      c_if.in_valid = 1'b1;
      c_if.in_data  = c_words[w];
      n = 0;
      while (!c_if.in_ready && n < 200) begin
        tick();
        n++;
      end
      tick();
      c_if.in_valid = 1'b0;
      chk($sformatf("c_par_%0d", w), c_par, c_pars[w]);
      rx = '0;
      for (int c = 0; c < 24; c++) begin
        if (c % 4 == 1) rx[c/4] = c_line;
        if (c < 23) tick();
      end
      chk($sformatf("c_framing_%0d", w), {rx[0], rx[5]}, 2'b01);
      chk($sformatf("c_data_%0d", w), rx[3:1], c_words[w]);
      chk($sformatf("c_line_par_%0d", w), rx[4], c_pars[w]);
      chk($sformatf("c_checker_%0d", w), ^rx[4:1], 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/even_parity_serial_tx.md
Name: even_parity_serial_tx

Overview:
Transmit side of the team's even-parity link. Accepts a parallel data word over a valid/ready handshake and computes the even parity bit. Serialises the frame onto one line: start bit, data LSB-first, parity, stop bit. The downstream even-parity checker recomputes XOR over data+parity and must see 0 for every frame this block sends.

Parameters:
DATA_W, 8, data bits per frame (>=1)
CLKS_PER_BIT, 4, clock cycles each serial bit is held on tx_serial (>=1)

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  upstream word valid
in_ready  output  1  block can accept a word this cycle
in_data  input  DATA_W  parallel word; sampled only on accept
tx_serial  output  1  serial line, idle high
tx_busy  output  1  high while a frame is on the line
frame_done  output  1  one-cycle pulse on the final cycle of the stop bit
parity_out  output  1  parity bit of the word currently or last latched

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; tx_serial=1, in_ready=0 while rst is high, tx_busy=0, frame_done=0, parity_out=0, counters=0.
- Reset mid-frame aborts the frame. Line is high on the cycle after the reset edge. No frame_done is issued. The partial frame is discarded.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: in_ready=1 (rst low), tx_serial=1, tx_busy=0.
- Accept = in_valid & in_ready.
- On accept:
  - latch in_data into the shift register;
  - parity_out <= XOR-reduce(in_data), so the count of 1s across data+parity is even;
  - go to START.
- in_valid while not in IDLE is ignored. No buffering. in_data changes after accept have no effect.
- START: tx_serial=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: tx_serial=shift_reg[0]; each bit held CLKS_PER_BIT cycles; shift right after each bit. After DATA_W bits, go to PARITY.
- PARITY: tx_serial=parity_out for CLKS_PER_BIT cycles, then STOP.
- STOP: tx_serial=1 for CLKS_PER_BIT cycles. frame_done=1 on the last of these cycles. Next state is IDLE.
- tx_busy=1 in START, DATA, PARITY and STOP; 0 in IDLE.
- Latency: the first start-bit cycle is the cycle after the accept edge. A frame occupies (DATA_W+3)*CLKS_PER_BIT cycles.
- Back-to-back: in_ready returns the cycle after frame_done. Minimum gap between frames is one idle-high cycle.
- Bit-time counter width: max(1,$clog2(CLKS_PER_BIT)). It wraps to 0 at CLKS_PER_BIT-1.
- Bit index counter width: max(1,$clog2(DATA_W)).
- CLKS_PER_BIT=1: each bit lasts exactly one cycle. frame_done coincides with the single STOP cycle.
- parity_out holds its value through IDLE until the next accept.

Decomposition:
- Shared package even_parity_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - START_LVL=0, STOP_LVL=1, IDLE_LVL=1;
  - function even_parity(data) = XOR-reduce.
- The checker side reuses the same package function.
- One sub-module: bit_tick_counter (CLKS_PER_BIT-cycle divider with clear input and bit_end output). It is also usable by a future serial receiver.

Test Plan:
1. DATA_W=8, CLKS_PER_BIT=4; accept 0xA5 -> parity_out=0. tx_serial holds each bit 4 cycles: 0 | 1,0,1,0,0,1,0,1 | 0 | 1. frame_done at cycle 44 after accept. in_ready high at cycle 45.
2. Accept 0x07 -> parity_out=1. Parity-bit slot on the line is 1. XOR of the 8 data bits and the parity bit = 0.
3. Assert in_valid with 0xFF during the DATA state of a 0x3C frame -> line still carries 0x3C with parity 0. 0xFF is not accepted until in_ready=1.
4. Assert rst for 1 cycle mid-DATA -> next cycle tx_serial=1, tx_busy=0, no frame_done pulse. After rst drops, in_ready=1 and a fresh frame of 0x81 (parity 0) transmits correctly.
5. CLKS_PER_BIT=1, in_valid held high with words 0x01, 0x03:
   - each frame is 11 cycles;
   - exactly one idle-high cycle between frames;
   - parities 1 then 0.
6. DATA_W=3 loopback into the 4-input even-parity checker: words 3'b111, 3'b101, 3'b001, 3'b000 give parity 1, 0, 1, 0. Checker output is 0 for all four.
